or1200_gpio_wb: RTL and testbench

Wishbone B3 classic slave GPIO controller that sits on the or1200 SoC data bus and drives the top-level `gpio_out` pins and samples `gpio_in`. It is the bus responder to the CPU's Wishbone initiator. It provides data/direction registers, a two-flop input synchronizer, and a per-bit edge-detect interrupt. The SoC-level bench sees only its pins: it drives `gpio_in` and watches `gpio_out`, where all-ones ends a test.

---
 rtl/or1200_gpio_pkg.sv | 13 +
 rtl/or1200_gpio_sync.sv | 26 ++
 rtl/or1200_gpio_wb.sv | 85 ++++++++
 tb/tb_or1200_gpio_wb.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/or1200_gpio_pkg.sv
// or1200_gpio_pkg: register offsets, bus FSM states and byte-lane helper for the GPIO slave
package or1200_gpio_pkg;
  localparam logic [2:0] GPIO_DIN  = 3'd0;
  localparam logic [2:0] GPIO_DOUT = 3'd1;
  localparam logic [2:0] GPIO_OE   = 3'd2;
  localparam logic [2:0] GPIO_IEN  = 3'd3;
  localparam logic [2:0] GPIO_ISR  = 3'd4;
  localparam logic [2:0] GPIO_EDGE = 3'd5;
  typedef enum logic {IDLE, RESP} state_e;
  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction
endpackage

// File: rtl/or1200_gpio_sync.sv
// or1200_gpio_sync: two-flop pin synchronizer followed by a per-bit edge detector
module or1200_gpio_sync #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  input  logic [W-1:0] edge_sel_i,
  output logic [W-1:0] din,
  output logic [W-1:0] edge_hit
);
  logic [W-1:0] sync1_q, sync2_q, prev_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  assign din = sync2_q;
  // a bit changed and its new level matches the selected edge (1 = rising)
  assign edge_hit = (sync2_q ^ prev_q) & ~(sync2_q ^ edge_sel_i);
endmodule

// File: rtl/or1200_gpio_wb.sv
// or1200_gpio_wb: Wishbone classic GPIO slave with data/direction registers and edge interrupts
module or1200_gpio_wb
  import or1200_gpio_pkg::*;
#(
  parameter int          GPIO_W  = 32,
  parameter logic [31:0] OUT_RST = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [2:0]        wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq_o
);
  logic [GPIO_W-1:0] din, edge_hit, wm, wd;
  logic [GPIO_W-1:0] dout_q, dout_d, oe_q, oe_d, ien_q, ien_d, isr_q, isr_d, edge_q, edge_d;
  logic [31:0] m32, rd, dat_q;
  logic req, wr, bad, ack_q, err_q;
  state_e state_q;
  or1200_gpio_sync #(.W(GPIO_W)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_i        (gpio_in),
    .edge_sel_i (edge_q),
    .din        (din),
    .edge_hit   (edge_hit)
  );
  always_comb begin
    m32 = sel_mask(wb_sel_i);
    wm = m32[GPIO_W-1:0];
    wd = wb_dat_i[GPIO_W-1:0] & wm;
    req = wb_cyc_i & wb_stb_i & (state_q == IDLE);
    bad = wb_adr_i > GPIO_EDGE;
    wr = req & wb_we_i;
    dout_d = (wr && wb_adr_i == GPIO_DOUT) ? (dout_q & ~wm) | wd : dout_q;
    oe_d = (wr && wb_adr_i == GPIO_OE) ? (oe_q & ~wm) | wd : oe_q;
    ien_d = (wr && wb_adr_i == GPIO_IEN) ? (ien_q & ~wm) | wd : ien_q;
    edge_d = (wr && wb_adr_i == GPIO_EDGE) ? (edge_q & ~wm) | wd : edge_q;
    isr_d = (isr_q & ~((wr && wb_adr_i == GPIO_ISR) ? wd : '0)) | edge_hit;
    rd = (wb_adr_i == GPIO_DIN)  ? 32'(din)    :
         (wb_adr_i == GPIO_DOUT) ? 32'(dout_q) :
         (wb_adr_i == GPIO_OE)   ? 32'(oe_q)   :
         (wb_adr_i == GPIO_IEN)  ? 32'(ien_q)  :
         (wb_adr_i == GPIO_ISR)  ? 32'(isr_q)  :
         (wb_adr_i == GPIO_EDGE) ? 32'(edge_q) : 32'h0;
  end
  // one response cycle per request; a strobe seen during RESP is not a new request
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      dout_q  <= OUT_RST[GPIO_W-1:0];
      oe_q    <= '0;
      ien_q   <= '0;
      isr_q   <= '0;
      edge_q  <= '0;
    end else begin
      state_q <= req ? RESP : IDLE;
      ack_q   <= req & ~bad;
      err_q   <= req & bad;
      dat_q   <= (req & ~wb_we_i) ? rd : '0;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      ien_q   <= ien_d;
      isr_q   <= isr_d;
      edge_q  <= edge_d;
    end
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = dat_q;
  assign gpio_out = dout_q & oe_q;
  assign gpio_oe  = oe_q;
  assign irq_o    = |(isr_q & ien_q);
endmodule

// File: tb/tb_or1200_gpio_wb.sv
// tb_or1200_gpio_wb: directed bench comparing the GPIO slave against a register-map model every cycle
module tb_or1200_gpio_wb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [2:0] wb_adr_i = 3'd0;
  logic [3:0] wb_sel_i = 4'd0;
  logic [31:0] wb_dat_i = 32'h0;
  logic [31:0] wb_dat_o;
  logic wb_ack_o, wb_err_o, irq_o;
  logic [31:0] gpio_in = 32'h0;
  logic [31:0] gpio_out, gpio_oe;
  int n_chk = 0, n_fail = 0;
  bit [31:0] m_dout, m_oe, m_ien, m_isr, m_edge, m_dat, m_din, m_hits, m_rd;
  bit m_busy, m_ack, m_err;
  bit [31:0] hist[$];

  or1200_gpio_wb #(.GPIO_W(32), .OUT_RST(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Model: pins sampled at each edge go into a 3-deep history; DATA_IN is the sample from two
  // edges back and an edge is flagged when that sample differs from the one before it.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_dout = 32'h0; m_oe = 32'h0; m_ien = 32'h0; m_isr = 32'h0; m_edge = 32'h0;
      m_busy = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_dat = 32'h0;
      hist = '{32'h0, 32'h0, 32'h0};
    end else begin
      m_din = hist[1];
      for (int i = 0; i < 32; i++)
        m_hits[i] = (hist[1][i] != hist[0][i]) && (hist[1][i] == m_edge[i]);
      if (m_busy) begin
        m_busy = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_dat = 32'h0;
      end else if (wb_cyc_i && wb_stb_i) begin
        m_busy = 1'b1;
        m_err = wb_adr_i >= 3'd6;
        m_ack = !m_err;
        case (wb_adr_i)
          3'd0: m_rd = m_din;
          3'd1: m_rd = m_dout;
          3'd2: m_rd = m_oe;
          3'd3: m_rd = m_ien;
          3'd4: m_rd = m_isr;
          3'd5: m_rd = m_edge;
          default: m_rd = 32'h0;
        endcase
        m_dat = wb_we_i ? 32'h0 : m_rd;
        if (wb_we_i)
          for (int k = 0; k < 4; k++)
            if (wb_sel_i[k])
              case (wb_adr_i)
                3'd1: m_dout[8*k +: 8] = wb_dat_i[8*k +: 8];
                3'd2: m_oe[8*k +: 8] = wb_dat_i[8*k +: 8];
                3'd3: m_ien[8*k +: 8] = wb_dat_i[8*k +: 8];
                3'd4: m_isr[8*k +: 8] = m_isr[8*k +: 8] & ~wb_dat_i[8*k +: 8];
                3'd5: m_edge[8*k +: 8] = wb_dat_i[8*k +: 8];
                default: ;
              endcase
      end else begin
        m_ack = 1'b0; m_err = 1'b0; m_dat = 32'h0;
      end
      m_isr = m_isr | m_hits;
      hist.push_back(gpio_in);
      void'(hist.pop_front());
    end
  end

  initial forever begin
    @(negedge clk);
    check("ack", {31'b0, wb_ack_o}, {31'b0, m_ack});
    check("err", {31'b0, wb_err_o}, {31'b0, m_err});
    check("dat", wb_dat_o, m_dat);
    check("gpio_out", gpio_out, m_dout & m_oe);
    check("gpio_oe", gpio_oe, m_oe);
    check("irq", {31'b0, irq_o}, {31'b0, |(m_isr & m_ien)});
  end

  task automatic xfer(input bit we, input bit [2:0] adr, input bit [3:0] sel,
                      input bit [31:0] d, output bit [31:0] r);
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = d;
    @(negedge clk);
    r = wb_dat_o;
    check("resp_latency", {30'b0, wb_err_o, wb_ack_o}, (adr >= 3'd6) ? 32'd2 : 32'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit [31:0] r;
    repeat (3) @(negedge clk);
    check("rst_gpio_out", gpio_out, 32'h0);
    check("rst_irq", {31'b0, irq_o}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ack", {31'b0, wb_ack_o}, 32'h0);
    xfer(1'b0, 3'd1, 4'hF, 32'h0, r); check("rst_dout_read", r, 32'h0);
    xfer(1'b1, 3'd1, 4'hF, 32'hFFFF_FFFF, r);
    xfer(1'b1, 3'd2, 4'hF, 32'hFFFF_FFFF, r);
    check("gpio_out_in_ack", gpio_out, 32'hFFFF_FFFF);
    @(negedge clk); gpio_in = 32'hA5A5_A5A5;
    repeat (2) @(negedge clk);
    xfer(1'b0, 3'd0, 4'hF, 32'h0, r); check("din_read", r, 32'hA5A5_A5A5);
    xfer(1'b1, 3'd1, 4'hF, 32'h0, r);
    xfer(1'b1, 3'd1, 4'b0100, 32'h1234_5678, r);
    xfer(1'b0, 3'd1, 4'hF, 32'h0, r); check("byte_write", r, 32'h0034_0000);
    xfer(1'b1, 3'd1, 4'h0, 32'hFFFF_FFFF, r);
    xfer(1'b0, 3'd1, 4'hF, 32'h0, r); check("sel0_write", r, 32'h0034_0000);
    xfer(1'b1, 3'd2, 4'hF, 32'h00F0_0000, r);
    check("oe_gating", gpio_out, 32'h0030_0000);
    xfer(1'b1, 3'd2, 4'hF, 32'hFFFF_FFFF, r);
    @(negedge clk); gpio_in = 32'h0;
    repeat (4) @(negedge clk);
    xfer(1'b0, 3'd4, 4'hF, 32'h0, r); check("falling_isr", r, 32'hA5A5_A5A5);
    xfer(1'b1, 3'd4, 4'hF, 32'hFFFF_FFFF, r);
    xfer(1'b0, 3'd4, 4'hF, 32'h0, r); check("isr_cleared", r, 32'h0);
    xfer(1'b1, 3'd5, 4'hF, 32'h1, r);
    xfer(1'b1, 3'd3, 4'hF, 32'h1, r);
    @(negedge clk); gpio_in[0] = 1'b1;
    @(negedge clk); check("irq_cycle1", {31'b0, irq_o}, 32'h0);
    @(negedge clk); check("irq_cycle2", {31'b0, irq_o}, 32'h0);
    @(negedge clk); check("irq_cycle3", {31'b0, irq_o}, 32'h1);
    xfer(1'b1, 3'd4, 4'hF, 32'h1, r); check("irq_clear_ack", {31'b0, irq_o}, 32'h0);
    @(negedge clk); gpio_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("falling_ignored", {31'b0, irq_o}, 32'h0);
    @(negedge clk); gpio_in[0] = 1'b1;
    @(negedge clk);
    xfer(1'b1, 3'd4, 4'hF, 32'h1, r); check("set_wins", {31'b0, irq_o}, 32'h1);
    xfer(1'b0, 3'd4, 4'hF, 32'h0, r); check("set_wins_isr", r, 32'h1);
    xfer(1'b1, 3'd3, 4'hF, 32'h0, r); check("ien_gates_irq", {31'b0, irq_o}, 32'h0);
    xfer(1'b0, 3'd4, 4'hF, 32'h0, r); check("isr_kept", r, 32'h1);
    xfer(1'b1, 3'd6, 4'hF, 32'hFFFF_FFFF, r);
    xfer(1'b0, 3'd7, 4'hF, 32'h0, r); check("err_read_zero", r, 32'h0);
    xfer(1'b1, 3'd0, 4'hF, 32'hFFFF_FFFF, r);
    xfer(1'b0, 3'd1, 4'hF, 32'h0, r); check("dout_untouched", r, 32'h0034_0000);
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 3'd1; wb_sel_i = 4'hF; wb_dat_i = 32'hDEAD_BEEF;
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_out", gpio_out, 32'h0);
    check("async_rst_oe", gpio_oe, 32'h0);
    repeat (2) @(negedge clk);
    check("abort_no_ack", {31'b0, wb_ack_o}, 32'h0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_ack2", {31'b0, wb_ack_o}, 32'h0);
    xfer(1'b0, 3'd1, 4'hF, 32'h0, r); check("rst_dout_again", r, 32'h0);
    xfer(1'b0, 3'd5, 4'hF, 32'h0, r); check("rst_edge_sel", r, 32'h0);
    repeat (3) @(negedge clk);
    xfer(1'b0, 3'd4, 4'hF, 32'h0, r); check("rst_rise_not_flagged", r, 32'h0);
    xfer(1'b0, 3'd0, 4'hF, 32'h0, r); check("din_after_rst", r, 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
